alt_vipitc120_is2vid_ctrl_decode: RTL and testbench

ALT_VIPITC120_IS2VID_CTRL_DECODE -- requirements
Module: alt_vipitc120_IS2Vid_ctrl_decode

---
 rtl/alt_vipitc120_is2vid_ctrl_decode.sv | 158 +++++++++++++++
 tb/tb_alt_vipitc120_is2vid_ctrl_decode.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alt_vipitc120_is2vid_ctrl_decode.sv
// Control-packet decoder for the IS2Vid path. It latches frame geometry from type-15 packets and passes type-0 video packets through.
// Optional build macro IS2VID_CTRL_RANGE_CHECK_EN rejects out-of-range geometry at commit.
module alt_vipitc120_is2vid_ctrl_decode #(
  parameter int DEFAULT_WIDTH  = 800,
  parameter int DEFAULT_HEIGHT = 480,
  parameter int MAX_WIDTH      = 1920,
  parameter int MAX_HEIGHT     = 1080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din_valid,
  input  logic        din_sop,
  input  logic        din_eop,
  input  logic [3:0]  din_data,
  output logic        din_ready,
  output logic        dout_valid,
  output logic        dout_sop,
  output logic        dout_eop,
  output logic [3:0]  dout_data,
  input  logic        dout_ready,
  output logic [15:0] width,
  output logic [15:0] height,
  output logic [3:0]  interlaced,
  output logic        ctrl_update,
  output logic        ctrl_error
);

  typedef enum logic [3:0] {
    S_WAIT_SOP, S_W3, S_W2, S_W1, S_W0,
    S_H3, S_H2, S_H1, S_H0, S_INTL, S_DRAIN, S_VIDEO
  } state_t;

  state_t      state, state_next;
  logic [15:0] shadow_width, shadow_height;
  logic        accept, fwd_sop, in_ctrl;
  logic        do_load, do_commit, do_error;
  logic        geometry_ok;

`ifdef IS2VID_CTRL_RANGE_CHECK_EN
  assign geometry_ok = (shadow_width  != 16'd0) && ({16'd0, shadow_width}  <= 32'(MAX_WIDTH)) &&
                       (shadow_height != 16'd0) && ({16'd0, shadow_height} <= 32'(MAX_HEIGHT));
`else
  assign geometry_ok = 1'b1;
`endif

  assign fwd_sop = din_sop && (din_data == 4'd0);
  assign in_ctrl = (state != S_WAIT_SOP) && (state != S_DRAIN) && (state != S_VIDEO);

  always_comb begin
    state_next = state;
    din_ready  = 1'b1;
    dout_valid = 1'b0;
    dout_sop   = 1'b0;
    dout_eop   = 1'b0;
    dout_data  = 4'd0;
    do_load    = 1'b0;
    do_commit  = 1'b0;
    do_error   = 1'b0;

    // A type-0 sop is forwarded from any non-video state, since it may abort a packet in flight
    if (state == S_VIDEO || fwd_sop) begin
      din_ready  = dout_ready;
      dout_valid = din_valid;
      dout_sop   = din_sop;
      dout_eop   = din_eop;
      dout_data  = din_data;
    end
    accept = din_valid && din_ready;

    if (accept) begin
      if (state == S_VIDEO) begin
        if (din_eop) state_next = S_WAIT_SOP;
      end else if (din_sop) begin
        if (in_ctrl) do_error = 1'b1;
        case (din_data)
          4'hF: begin
            if (din_eop) begin
              do_error   = 1'b1;
              state_next = S_WAIT_SOP;
            end else begin
              state_next = S_W3;
            end
          end
          4'h0:    state_next = din_eop ? S_WAIT_SOP : S_VIDEO;
          default: state_next = din_eop ? S_WAIT_SOP : S_DRAIN;
        endcase
      end else begin
        case (state)
          S_W3, S_W2, S_W1, S_W0, S_H3, S_H2, S_H1, S_H0: begin
            if (din_eop) begin
              do_error   = 1'b1;
              state_next = S_WAIT_SOP;
            end else begin
              do_load = 1'b1;
              case (state)
                S_W3:    state_next = S_W2;
                S_W2:    state_next = S_W1;
                S_W1:    state_next = S_W0;
                S_W0:    state_next = S_H3;
                S_H3:    state_next = S_H2;
                S_H2:    state_next = S_H1;
                S_H1:    state_next = S_H0;
                default: state_next = S_INTL;
              endcase
            end
          end
          S_INTL: begin
            do_commit  = 1'b1;
            state_next = din_eop ? S_WAIT_SOP : S_DRAIN;
          end
          S_DRAIN: begin
            if (din_eop) state_next = S_WAIT_SOP;
          end
          default: state_next = state;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_WAIT_SOP;
    else     state <= state_next;
  end

  // Shadow nibbles are loaded MSB first; geometry only moves when the interlace nibble commits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_width  <= 16'd0;
      shadow_height <= 16'd0;
      width         <= 16'(DEFAULT_WIDTH);
      height        <= 16'(DEFAULT_HEIGHT);
      interlaced    <= 4'd0;
      ctrl_update   <= 1'b0;
      ctrl_error    <= 1'b0;
    end else begin
      ctrl_update <= do_commit && geometry_ok;
      ctrl_error  <= do_error || (do_commit && !geometry_ok);
      if (do_load) begin
        case (state)
          S_W3:    shadow_width[15:12]  <= din_data;
          S_W2:    shadow_width[11:8]   <= din_data;
          S_W1:    shadow_width[7:4]    <= din_data;
          S_W0:    shadow_width[3:0]    <= din_data;
          S_H3:    shadow_height[15:12] <= din_data;
          S_H2:    shadow_height[11:8]  <= din_data;
          S_H1:    shadow_height[7:4]   <= din_data;
          default: shadow_height[3:0]   <= din_data;
        endcase
      end
      if (do_commit && geometry_ok) begin
        width      <= shadow_width;
        height     <= shadow_height;
        interlaced <= din_data;
      end
    end
  end

endmodule

// File: tb/tb_alt_vipitc120_is2vid_ctrl_decode.sv
// Table-driven bench for alt_vipitc120_is2vid_ctrl_decode: each row is one cycle of input plus expected outputs.
module tb_alt_vipitc120_is2vid_ctrl_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din_valid = 1'b0, din_sop = 1'b0, din_eop = 1'b0;
  logic [3:0]  din_data = 4'd0;
  logic        din_ready;
  logic        dout_valid, dout_sop, dout_eop;
  logic [3:0]  dout_data;
  logic        dout_ready = 1'b1;
  logic [15:0] width, height;
  logic [3:0]  interlaced;
  logic        ctrl_update, ctrl_error;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alt_vipitc120_is2vid_ctrl_decode dut (
    .clk(clk), .rst(rst),
    .din_valid(din_valid), .din_sop(din_sop), .din_eop(din_eop), .din_data(din_data),
    .din_ready(din_ready),
    .dout_valid(dout_valid), .dout_sop(dout_sop), .dout_eop(dout_eop), .dout_data(dout_data),
    .dout_ready(dout_ready),
    .width(width), .height(height), .interlaced(interlaced),
    .ctrl_update(ctrl_update), .ctrl_error(ctrl_error)
  );

  typedef struct {
    logic        v, s, e;
    logic [3:0]  d;
    logic        dr;
    logic        er, eo, eu, ee;
    logic [15:0] ew, eh;
    logic [3:0]  ei;
  } vec_t;

  vec_t tbl[$];

  localparam logic [15:0] W0 = 16'h0320, H0 = 16'h01E0;
  localparam logic [15:0] W1 = 16'h0400, H1 = 16'h0258;
`ifdef IS2VID_CTRL_RANGE_CHECK_EN
  localparam logic [15:0] RW = W1, RH = H1;
  localparam logic [3:0]  RI = 4'd3;
  localparam logic        RU = 1'b0, RE = 1'b1;
`else
  localparam logic [15:0] RW = 16'h0800, RH = 16'h0258;
  localparam logic [3:0]  RI = 4'd1;
  localparam logic        RU = 1'b1, RE = 1'b0;
`endif

  task automatic row(input logic v, s, e, input logic [3:0] d, input logic dr,
                     input logic er, eo, eu, ee,
                     input logic [15:0] ew, eh, input logic [3:0] ei);
    vec_t t;
    t.v = v; t.s = s; t.e = e; t.d = d; t.dr = dr;
    t.er = er; t.eo = eo; t.eu = eu; t.ee = ee;
    t.ew = ew; t.eh = eh; t.ei = ei;
    tbl.push_back(t);
  endtask

  task automatic checkGeo(input string name, input logic [15:0] ew, eh, input logic [3:0] ei,
                          input logic eu, ee);
    logic [37:0] act, exp;
    act = {width, height, interlaced, ctrl_update, ctrl_error};
    exp = {ew, eh, ei, eu, ee};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s geo: got w=%h h=%h i=%h upd=%b err=%b, expected w=%h h=%h i=%h upd=%b err=%b",
               name, width, height, interlaced, ctrl_update, ctrl_error, ew, eh, ei, eu, ee);
    end
  endtask

  task automatic checkOutput(input int idx, input vec_t t);
    logic [7:0] act, exp;
    act = {din_ready, dout_valid, dout_valid ? {dout_sop, dout_eop, dout_data} : 6'd0};
    exp = {t.er, t.eo, t.eo ? {t.s, t.e, t.d} : 6'd0};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL row%0d hs: got %b expected %b (ready,valid,sop,eop,data)", idx, act, exp);
    end
    checkGeo($sformatf("row%0d", idx), t.ew, t.eh, t.ei, t.eu, t.ee);
  endtask

  task automatic applyStimulus(input int idx, input vec_t t);
    @(negedge clk);
    din_valid  = t.v;
    din_sop    = t.s;
    din_eop    = t.e;
    din_data   = t.d;
    dout_ready = t.dr;
    #1;
    checkOutput(idx, t);
  endtask

  initial begin
    // Control packet F,0,4,0,0,0,2,5,8,3(eop)
    row(0,0,0,4'h0,1, 1,0,0,0, W0,H0,0);
    row(1,1,0,4'hF,1, 1,0,0,0, W0,H0,0);
    row(1,0,0,4'h0,1, 1,0,0,0, W0,H0,0);
    row(1,0,0,4'h4,1, 1,0,0,0, W0,H0,0);
    row(1,0,0,4'h0,1, 1,0,0,0, W0,H0,0);
    row(1,0,0,4'h0,1, 1,0,0,0, W0,H0,0);
    row(1,0,0,4'h0,1, 1,0,0,0, W0,H0,0);
    row(1,0,0,4'h2,1, 1,0,0,0, W0,H0,0);
    row(1,0,0,4'h5,1, 1,0,0,0, W0,H0,0);
    row(1,0,0,4'h8,1, 1,0,0,0, W0,H0,0);
    row(1,0,1,4'h3,1, 1,0,0,0, W0,H0,0);
    row(0,0,0,4'h0,1, 1,0,1,0, W1,H1,3);
    row(0,0,0,4'h0,1, 1,0,0,0, W1,H1,3);
    // Video packet, five beats, dout_ready toggling
    row(1,1,0,4'h0,1, 1,1,0,0, W1,H1,3);
    row(1,0,0,4'hA,0, 0,1,0,0, W1,H1,3);
    row(1,0,0,4'hA,1, 1,1,0,0, W1,H1,3);
    row(1,0,0,4'hB,0, 0,1,0,0, W1,H1,3);
    row(1,0,0,4'hB,1, 1,1,0,0, W1,H1,3);
    row(1,0,0,4'hC,1, 1,1,0,0, W1,H1,3);
    row(1,0,1,4'hD,0, 0,1,0,0, W1,H1,3);
    row(1,0,1,4'hD,1, 1,1,0,0, W1,H1,3);
    row(1,0,0,4'h7,0, 1,0,0,0, W1,H1,3);
    // Truncated at H2
    row(1,1,0,4'hF,1, 1,0,0,0, W1,H1,3);
    row(1,0,0,4'h1,1, 1,0,0,0, W1,H1,3);
    row(1,0,0,4'h2,1, 1,0,0,0, W1,H1,3);
    row(1,0,0,4'h3,1, 1,0,0,0, W1,H1,3);
    row(1,0,0,4'h4,1, 1,0,0,0, W1,H1,3);
    row(1,0,0,4'h0,1, 1,0,0,0, W1,H1,3);
    row(1,0,1,4'h9,1, 1,0,0,0, W1,H1,3);
    row(0,0,0,4'h0,1, 1,0,0,1, W1,H1,3);
    row(0,0,0,4'h0,1, 1,0,0,0, W1,H1,3);
    row(1,1,1,4'h0,1, 1,1,0,0, W1,H1,3);
    row(1,1,0,4'h0,1, 1,1,0,0, W1,H1,3);
    row(1,0,1,4'h5,1, 1,1,0,0, W1,H1,3);
    // Abort by type-0 sop at W1
    row(1,1,0,4'hF,1, 1,0,0,0, W1,H1,3);
    row(1,0,0,4'h1,1, 1,0,0,0, W1,H1,3);
    row(1,0,0,4'h2,1, 1,0,0,0, W1,H1,3);
    row(1,1,0,4'h0,0, 0,1,0,0, W1,H1,3);
    row(1,1,0,4'h0,1, 1,1,0,0, W1,H1,3);
    row(1,0,0,4'h6,1, 1,1,0,1, W1,H1,3);
    row(1,0,1,4'h7,1, 1,1,0,0, W1,H1,3);
    row(0,0,0,4'h0,1, 1,0,0,0, W1,H1,3);
    // Unknown type drains to eop
    row(1,1,0,4'h3,1, 1,0,0,0, W1,H1,3);
    row(1,0,0,4'h0,0, 1,0,0,0, W1,H1,3);
    row(1,0,1,4'h1,1, 1,0,0,0, W1,H1,3);
    row(1,1,1,4'h0,1, 1,1,0,0, W1,H1,3);
    // Width 0x0800, interlace beat without eop then drained
    row(1,1,0,4'hF,1, 1,0,0,0, W1,H1,3);
    row(1,0,0,4'h0,1, 1,0,0,0, W1,H1,3);
    row(1,0,0,4'h8,1, 1,0,0,0, W1,H1,3);
    row(1,0,0,4'h0,1, 1,0,0,0, W1,H1,3);
    row(1,0,0,4'h0,1, 1,0,0,0, W1,H1,3);
    row(1,0,0,4'h0,1, 1,0,0,0, W1,H1,3);
    row(1,0,0,4'h2,1, 1,0,0,0, W1,H1,3);
    row(1,0,0,4'h5,1, 1,0,0,0, W1,H1,3);
    row(1,0,0,4'h8,1, 1,0,0,0, W1,H1,3);
    row(1,0,0,4'h1,1, 1,0,0,0, W1,H1,3);
    row(1,0,1,4'h2,1, 1,0,RU,RE, RW,RH,RI);
    row(0,0,0,4'h0,1, 1,0,0,0, RW,RH,RI);
    // sop+eop type 15 is truncated
    row(1,1,1,4'hF,1, 1,0,0,0, RW,RH,RI);
    row(0,0,0,4'h0,1, 1,0,0,1, RW,RH,RI);
    // Start of a packet that reset will cut short
    row(1,1,0,4'hF,1, 1,0,0,0, RW,RH,RI);
    row(1,0,0,4'h1,1, 1,0,0,0, RW,RH,RI);

    repeat (3) @(negedge clk);
    checkGeo("reset", W0, H0, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    checkGeo("idle", W0, H0, 4'd0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) applyStimulus(i, tbl[i]);

    // Asynchronous reset mid-packet: no commit, no error, decoding restarts in WAIT_SOP
    @(negedge clk);
    din_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    checkGeo("midrst", W0, H0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    begin
      vec_t t;
      t = '{v:1, s:0, e:1, d:4'h3, dr:1, er:1, eo:0, eu:0, ee:0, ew:W0, eh:H0, ei:0};
      applyStimulus(100, t);
      t = '{v:1, s:1, e:1, d:4'h0, dr:1, er:1, eo:1, eu:0, ee:0, ew:W0, eh:H0, ei:0};
      applyStimulus(101, t);
      t = '{v:0, s:0, e:0, d:4'h0, dr:1, er:1, eo:0, eu:0, ee:0, ew:W0, eh:H0, ei:0};
      applyStimulus(102, t);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
